amp_predistort: RTL and testbench
=================================

// Module: amp_predistort
// PURPOSE
//  LUT-based amplitude predistortion for a real signed sample stream ahead of a DAC/PA.
//  Each input sample is scaled by a gain read from a 2^DEPTH-entry table indexed by |x|.
//  The gain table is loaded at run time over a separate AXI-stream taps port.
//  Input and output are AXI-stream; output is saturated to WIDTH bits.
// PARAMETERS
//  WIDTH     16  sample and gain word width (signed two's complement)
//  DEPTH     7   table address bits; 2^DEPTH gain entries
//  DROPBITS  10  gain fractional bits; unity gain = 2^DROPBITS; product >>> DROPBITS
// PORTS
//  clk          in   1      clock
//  reset        in   1      reset, asynchronous, active-low
//  clear        in   1      sync clear: flush pipeline, zero taps write pointer (table kept)
//  i_tdata      in   WIDTH  signed input sample
//  i_tlast      in   1      packet end, carried with sample
//  i_tvalid     in   1      input valid
//  i_tready     out  1      input ready
//  o_tdata      out  WIDTH  predistorted signed sample
//  o_tlast      out  1      i_tlast delayed with its sample
//  o_tvalid     out  1      output valid
//  o_tready     in   1      downstream ready
//  taps_tdata   in   WIDTH  signed gain word (Q.DROPBITS)
//  taps_tlast   in   1      last tap of a table load
//  taps_tvalid  in   1      tap valid
//  taps_tready  out  1      tap ready; always 1 out of reset
// BEHAVIOUR
//  - Reset (reset=0): all pipeline valids 0, o_tvalid=0, o_tdata=0, o_tlast=0, taps pointer=0,
//    every table entry = 2^DROPBITS (unity gain). clear has the same effect except table kept.
//  - Index: mag = |i_tdata|, with -2^(WIDTH-1) mapped to 2^(WIDTH-1)-1;
//    idx = mag[WIDTH-2 -: DEPTH] (bits [14:8] for defaults).
//  - Pipeline, 3 stages, latency 3 cycles with o_tready=1:
//    S1 register x, tlast, gain=table[idx]; S2 p = x*gain (2*WIDTH signed);
//    S3 y = p >>> DROPBITS (floor, no rounding), saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//  - Handshake: global enable en = ~S3.valid | o_tready; i_tready = en; all stages advance
//    on en; i_tdata/i_tlast accepted on i_tvalid & en. Output held stable while
//    o_tvalid & ~o_tready. No bubbles: full throughput with o_tready=1.
//  - Taps write: on taps_tvalid, table[ptr] <= taps_tdata; ptr <= taps_tlast ? 0 : ptr+1
//    (wraps mod 2^DEPTH). Writes take effect for lookups in the following cycle; a write
//    and a lookup of the same entry in the same cycle returns the old value.
//  - Simultaneous clear and taps write: clear wins for the pointer, the write still lands.
// STRUCTURE
//  - Shared package: UNITY_GAIN = 2^DROPBITS, saturation limits SMAX/SMIN.
//  - Sub-module predistort_gain_lut: flop table, write pointer, combinational read port.
//  - Top: magnitude/index, 3-stage MAC + saturation pipeline, handshake.
// TESTING
//  1 Default table, x=0x1230 -> y=0x1230 three cycles later; ramp 0..0x7FF0 passes unchanged.
//  2 Load 128 taps of 2048 (last with tlast), x=0x1000 -> 0x2000; x=-0x1000 -> 0xE000.
//  3 Gains 2048, x=0x7FF0 -> 0x7FFF; x=0x8000 -> 0x8000 (saturated negative).
//  4 Tap k = 1024+k, x = k<<8 for k=0..127 -> y = ((k<<8)*(1024+k))>>>10, e.g. k=64 -> 0x4400.
//  5 o_tready toggled 50% random during a ramp -> no sample lost or duplicated, order kept,
//    o_tdata stable while stalled, o_tlast aligned with its sample.
//  6 Partial load of 3 taps + taps_tlast, then 3 more -> entries 0..2 rewritten by second load;
//    reset mid-stream -> o_tvalid drops immediately, table returns to unity.

Source files
------------

// File: rtl/amp_predistort_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : amp_predistort_pkg
//  Description : Shared constants for the amplitude predistortion block.
//                Default word/table geometry, unity gain and the signed
//                saturation limits of an output sample.
//  Revision    : 1.0 - initial release
// ============================================================================
package amp_predistort_pkg;

    localparam int PD_WIDTH    = 16;
    localparam int PD_DEPTH    = 7;
    localparam int PD_DROPBITS = 10;

    // Gain words are Q.DROPBITS, so unity is a single bit at DROPBITS.
    localparam logic signed [PD_WIDTH-1:0] UNITY_GAIN = PD_WIDTH'(1 << PD_DROPBITS);

    localparam logic signed [PD_WIDTH-1:0] SMAX = {1'b0, {(PD_WIDTH-1){1'b1}}};
    localparam logic signed [PD_WIDTH-1:0] SMIN = {1'b1, {(PD_WIDTH-1){1'b0}}};

endpackage : amp_predistort_pkg
`default_nettype wire

// File: rtl/amp_predistort_if.sv
`default_nettype none
// ============================================================================
//  Module      : amp_predistort_if
//  Description : AXI-stream style bundle used for the sample input, the
//                sample output and the gain-table load port.
//                  tdata  - WIDTH-bit signed word
//                  tlast  - packet / table-load end marker
//                  tvalid - producer has a word
//                  tready - consumer accepts the word
//  Revision    : 1.0 - initial release
// ============================================================================
interface amp_predistort_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface : amp_predistort_if
`default_nettype wire

// File: rtl/amp_predistort_gain_lut.sv
`default_nettype none
// ============================================================================
//  Module      : predistort_gain_lut
//  Description : 2^DEPTH-entry gain table held in flops, with a sequential
//                write pointer and a combinational read port.
//  Ports       : clk, reset (async, active-low), clear (sync, pointer only)
//                wr_valid/wr_data/wr_last - tap write stream
//                rd_idx -> rd_gain        - lookup (sees pre-write contents)
//  Revision    : 1.0 - initial release
// ============================================================================
module predistort_gain_lut
    import amp_predistort_pkg::*;
#(
    parameter int WIDTH    = PD_WIDTH,
    parameter int DEPTH    = PD_DEPTH,
    parameter int DROPBITS = PD_DROPBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    input  logic [DEPTH-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_gain
);

    localparam int               c_entries = 1 << DEPTH;
    localparam logic [WIDTH-1:0] c_unity   = WIDTH'(1 << DROPBITS);

    logic [WIDTH-1:0] r_table [c_entries];
    logic [DEPTH-1:0] r_ptr;

    // Clear only rewinds the pointer; a write presented in the same cycle
    // still lands at the old pointer position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
            for (int k = 0; k < c_entries; k++) begin
                r_table[k] <= c_unity;
            end
        end else begin
            if (wr_valid) begin
                r_table[r_ptr] <= wr_data;
            end
            if (clear) begin
                r_ptr <= '0;
            end else if (wr_valid) begin
                r_ptr <= wr_last ? '0 : r_ptr + DEPTH'(1);
            end
        end
    end

    // Read of the flop array: a same-cycle write is only visible next cycle.
    assign rd_gain = r_table[rd_idx];

endmodule : predistort_gain_lut
`default_nettype wire

// File: rtl/amp_predistort.sv
`default_nettype none
// ============================================================================
//  Module      : amp_predistort
//  Description : LUT-based amplitude predistortion. Each sample is scaled by
//                a gain looked up by its magnitude, then floored and
//                saturated back to WIDTH bits. Three-stage pipeline with a
//                single global enable (no bubbles at full throughput).
//  Ports       : clk, reset (async, active-low), clear (sync flush)
//                s_in   - input samples   (slave)
//                m_out  - output samples  (master)
//                s_taps - gain table load (slave, always ready)
//  Revision    : 1.0 - initial release
// ============================================================================
module amp_predistort
    import amp_predistort_pkg::*;
#(
    parameter int WIDTH    = PD_WIDTH,
    parameter int DEPTH    = PD_DEPTH,
    parameter int DROPBITS = PD_DROPBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    amp_predistort_if.slave  s_in,
    amp_predistort_if.master m_out,
    amp_predistort_if.slave  s_taps
);

    localparam logic signed [WIDTH-1:0]   c_smax   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   c_smin   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] c_sat_hi = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] c_sat_lo = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic                       w_en;
    logic signed [WIDTH-1:0]    w_x;
    logic        [WIDTH-1:0]    w_mag;
    logic        [DEPTH-1:0]    w_idx;
    logic        [WIDTH-1:0]    w_gain;
    logic signed [2*WIDTH-1:0]  w_shift;
    logic signed [WIDTH-1:0]    w_sat;

    logic                       r_v1, r_v2, r_v3;
    logic                       r_l1, r_l2, r_l3;
    logic signed [WIDTH-1:0]    r_x1, r_g1;
    logic signed [2*WIDTH-1:0]  r_p2;
    logic signed [WIDTH-1:0]    r_y3;

    // Whole pipeline moves together whenever the output slot can drain.
    assign w_en          = ~r_v3 | m_out.tready;
    assign s_in.tready   = w_en;
    assign s_taps.tready = 1'b1;

    // Magnitude; the most negative sample has no positive twin, so it is
    // folded onto the largest positive value.
    assign w_x = $signed(s_in.tdata);
    always_comb begin
        w_mag = w_x;
        if (w_x == c_smin) begin
            w_mag = c_smax;
        end else if (w_x[WIDTH-1]) begin
            w_mag = -w_x;
        end
    end

    // Top DEPTH magnitude bits below the (always zero) sign position.
    assign w_idx = DEPTH'(w_mag >> (WIDTH - 1 - DEPTH));

    predistort_gain_lut #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .DROPBITS (DROPBITS)
    ) u_lut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .wr_valid (s_taps.tvalid),
        .wr_data  (s_taps.tdata),
        .wr_last  (s_taps.tlast),
        .rd_idx   (w_idx),
        .rd_gain  (w_gain)
    );

    // Arithmetic shift floors toward minus infinity; then clamp.
    assign w_shift = r_p2 >>> DROPBITS;
    always_comb begin
        w_sat = WIDTH'(w_shift);
        if (w_shift > c_sat_hi) begin
            w_sat = c_smax;
        end else if (w_shift < c_sat_lo) begin
            w_sat = c_smin;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
            r_l1 <= 1'b0; r_l2 <= 1'b0; r_l3 <= 1'b0;
            r_x1 <= '0;   r_g1 <= '0;   r_p2 <= '0;   r_y3 <= '0;
        end else if (clear) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
            r_l1 <= 1'b0; r_l2 <= 1'b0; r_l3 <= 1'b0;
            r_x1 <= '0;   r_g1 <= '0;   r_p2 <= '0;   r_y3 <= '0;
        end else if (w_en) begin
            r_v1 <= s_in.tvalid;
            r_x1 <= w_x;
            r_l1 <= s_in.tlast;
            r_g1 <= $signed(w_gain);

            r_v2 <= r_v1;
            r_p2 <= r_x1 * r_g1;
            r_l2 <= r_l1;

            r_v3 <= r_v2;
            r_y3 <= w_sat;
            r_l3 <= r_l2;
        end
    end

    assign m_out.tvalid = r_v3;
    assign m_out.tdata  = r_y3;
    assign m_out.tlast  = r_l3;

endmodule : amp_predistort
`default_nettype wire

// File: tb/tb_amp_predistort.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amp_predistort
//  Description : Self-checking bench for amp_predistort. Random and directed
//                samples are compared with a reference model that computes
//                floor(x*gain/2^10) clamped to 16 bits from a software copy
//                of the gain table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_amp_predistort;
    import amp_predistort_pkg::*;

    localparam int W     = 16;
    localparam int D     = 7;
    localparam int DB    = 10;
    localparam int N_ENT = 128;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    amp_predistort_if #(.WIDTH(W)) in_if   ();
    amp_predistort_if #(.WIDTH(W)) out_if  ();
    amp_predistort_if #(.WIDTH(W)) taps_if ();

    amp_predistort #(
        .WIDTH    (W),
        .DEPTH    (D),
        .DROPBITS (DB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .s_in   (in_if.slave),
        .m_out  (out_if.master),
        .s_taps (taps_if.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference table state.
    int m_gain [N_ENT];
    int m_ptr;

    // Stream buffers shared by the driver and the tests.
    logic [15:0] tx_d [$];
    bit          tx_l [$];
    logic [15:0] ex_d [$];
    logic [15:0] rx_d [$];
    bit          rx_l [$];
    int          tap_q [$];
    int          stall_errs;

    function automatic void model_reset();
        for (int k = 0; k < N_ENT; k++) m_gain[k] = int'(UNITY_GAIN);
        m_ptr = 0;
    endfunction

    function automatic int model_y(input logic [15:0] xin);
        int     x, mag, idx;
        longint p, q;
        x   = int'($signed(xin));
        mag = (x == -32768) ? 32767 : ((x < 0) ? -x : x);
        idx = mag / 256;
        p   = longint'(x) * longint'(m_gain[idx]);
        q   = p / 1024;
        if (p < 0 && (p % 1024) != 0) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    // Drives tx_d/tx_l through the DUT and collects accepted outputs.
    task automatic run_stream(input bit rand_in, input bit rand_out, input int budget);
        int          sent = 0;
        int          cyc  = 0;
        bit          prev_stall = 0;
        logic [15:0] pd = '0;
        bit          pl = 0;
        rx_d.delete(); rx_l.delete(); stall_errs = 0;
        while (rx_d.size() < tx_d.size() && cyc < budget) begin
            @(negedge clk);
            if (sent < tx_d.size() && (!rand_in || $urandom_range(0, 3) != 0)) begin
                in_if.tvalid = 1'b1;
                in_if.tdata  = tx_d[sent];
                in_if.tlast  = tx_l[sent];
            end else begin
                in_if.tvalid = 1'b0;
                in_if.tdata  = 16'($urandom);
                in_if.tlast  = 1'b0;
            end
            out_if.tready = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall && (out_if.tvalid !== 1'b1 || out_if.tdata !== pd || out_if.tlast !== pl))
                stall_errs++;
            if (in_if.tvalid && in_if.tready) sent++;
            if (out_if.tvalid === 1'b1 && out_if.tready) begin
                rx_d.push_back(out_if.tdata);
                rx_l.push_back(out_if.tlast);
            end
            prev_stall = (out_if.tvalid === 1'b1) && !out_if.tready;
            pd = out_if.tdata;
            pl = out_if.tlast;
            cyc++;
        end
        @(negedge clk);
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;
    endtask

    task automatic load_taps(input bit last_at_end);
        for (int i = 0; i < tap_q.size(); i++) begin
            @(negedge clk);
            taps_if.tvalid = 1'b1;
            taps_if.tdata  = 16'(tap_q[i]);
            taps_if.tlast  = last_at_end && (i == tap_q.size() - 1);
            m_gain[m_ptr]  = tap_q[i];
            m_ptr          = taps_if.tlast ? 0 : (m_ptr + 1) % N_ENT;
        end
        @(negedge clk);
        taps_if.tvalid = 1'b0;
        taps_if.tlast  = 1'b0;
    endtask

    task automatic clear_bufs();
        tx_d.delete(); tx_l.delete(); ex_d.delete();
    endtask

    task automatic test_reset();
        in_if.tvalid = 0; in_if.tdata = '0; in_if.tlast = 0;
        out_if.tready = 1;
        taps_if.tvalid = 0; taps_if.tdata = '0; taps_if.tlast = 0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (out_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got=%b want=0", out_if.tvalid); end
        vectors++;
        if (out_if.tdata !== 16'h0) begin miscompares++; $display("FAIL reset_tdata got=%h want=0000", out_if.tdata); end
        vectors++;
        if (out_if.tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got=%b want=0", out_if.tlast); end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (taps_if.tready !== 1'b1) begin miscompares++; $display("FAIL taps_tready got=%b want=1", taps_if.tready); end
        vectors++;
        if (in_if.tready !== 1'b1) begin miscompares++; $display("FAIL idle_i_tready got=%b want=1", in_if.tready); end
    endtask

    task automatic test_latency();
        @(negedge clk);
        in_if.tvalid = 1; in_if.tdata = 16'h1230; in_if.tlast = 1;
        @(negedge clk);
        in_if.tvalid = 0; in_if.tlast = 0;
        @(negedge clk);
        vectors++;
        if (out_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL latency_early got=%b want=0", out_if.tvalid); end
        @(negedge clk);
        vectors++;
        if (out_if.tvalid !== 1'b1 || out_if.tdata !== 16'h1230 || out_if.tlast !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_3 got v=%b d=%h l=%b want v=1 d=1230 l=1", out_if.tvalid, out_if.tdata, out_if.tlast);
        end
        @(negedge clk);
        vectors++;
        if (out_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL latency_single got=%b want=0", out_if.tvalid); end
    endtask

    task automatic test_unity_ramp();
        clear_bufs();
        for (int v = 0; v <= 16'h7FF0; v += 16'h10) begin
            tx_d.push_back(16'(v));
            tx_l.push_back(((v >> 4) % 16) == 15);
        end
        run_stream(0, 0, 4000);
        vectors++;
        if (rx_d.size() != tx_d.size()) begin miscompares++; $display("FAIL ramp_count got=%0d want=%0d", rx_d.size(), tx_d.size()); end
        for (int i = 0; i < rx_d.size() && i < tx_d.size(); i++) begin
            vectors++;
            if (rx_d[i] !== tx_d[i] || rx_l[i] !== tx_l[i]) begin
                miscompares++;
                $display("FAIL ramp[%0d] got=%h/%b want=%h/%b", i, rx_d[i], rx_l[i], tx_d[i], tx_l[i]);
            end
        end
    endtask

    task automatic test_gain2_saturation();
        tap_q.delete();
        for (int k = 0; k < N_ENT; k++) tap_q.push_back(2048);
        load_taps(1);
        clear_bufs();
        tx_d = '{16'h1000, 16'hF000, 16'h7FF0, 16'h8000};
        ex_d = '{16'h2000, 16'hE000, 16'h7FFF, 16'h8000};
        for (int i = 0; i < 4; i++) tx_l.push_back(0);
        for (int i = 0; i < 20; i++) begin
            tx_d.push_back(16'($urandom));
            tx_l.push_back(1'($urandom));
            ex_d.push_back(16'(model_y(tx_d[tx_d.size()-1])));
        end
        run_stream(0, 0, 200);
        vectors++;
        if (rx_d.size() != tx_d.size()) begin miscompares++; $display("FAIL gain2_count got=%0d want=%0d", rx_d.size(), tx_d.size()); end
        for (int i = 0; i < rx_d.size() && i < ex_d.size(); i++) begin
            vectors++;
            if (rx_d[i] !== ex_d[i]) begin
                miscompares++;
                $display("FAIL gain2[%0d] x=%h got=%h want=%h", i, tx_d[i], rx_d[i], ex_d[i]);
            end
        end
    endtask

    task automatic test_ramp_taps();
        tap_q.delete();
        for (int k = 0; k < N_ENT; k++) tap_q.push_back(1024 + k);
        load_taps(1);
        clear_bufs();
        for (int k = 0; k < N_ENT; k++) begin
            tx_d.push_back(16'(k << 8));
            tx_l.push_back(k == N_ENT - 1);
            ex_d.push_back(16'(model_y(16'(k << 8))));
        end
        run_stream(0, 0, 400);
        vectors++;
        if (rx_d.size() != tx_d.size()) begin miscompares++; $display("FAIL taps_ramp_count got=%0d want=%0d", rx_d.size(), tx_d.size()); end
        for (int i = 0; i < rx_d.size() && i < ex_d.size(); i++) begin
            vectors++;
            if (rx_d[i] !== ex_d[i]) begin
                miscompares++;
                $display("FAIL taps_ramp[%0d] got=%h want=%h", i, rx_d[i], ex_d[i]);
            end
        end
        if (rx_d.size() > 64) begin
            vectors++;
            if (rx_d[64] !== 16'h4400) begin miscompares++; $display("FAIL taps_ramp_k64 got=%h want=4400", rx_d[64]); end
        end
    endtask

    task automatic test_back_to_back_stall();
        // 128 taps without tlast also exercises pointer wrap back to 0.
        tap_q.delete();
        for (int k = 0; k < N_ENT; k++) tap_q.push_back($urandom_range(0, 8191) - 4096);
        load_taps(0);
        clear_bufs();
        for (int i = 0; i < 300; i++) begin
            tx_d.push_back(16'($urandom));
            tx_l.push_back(($urandom_range(0, 7)) == 0);
            ex_d.push_back(16'(model_y(tx_d[i])));
        end
        run_stream(1, 1, 3000);
        vectors++;
        if (rx_d.size() != tx_d.size()) begin miscompares++; $display("FAIL stall_count got=%0d want=%0d", rx_d.size(), tx_d.size()); end
        vectors++;
        if (stall_errs != 0) begin miscompares++; $display("FAIL stall_hold got=%0d changes want=0", stall_errs); end
        for (int i = 0; i < rx_d.size() && i < ex_d.size(); i++) begin
            vectors++;
            if (rx_d[i] !== ex_d[i] || rx_l[i] !== tx_l[i]) begin
                miscompares++;
                $display("FAIL stall[%0d] got=%h/%b want=%h/%b", i, rx_d[i], rx_l[i], ex_d[i], tx_l[i]);
            end
        end
    endtask

    task automatic stream_model_check(input string name, input int n);
        clear_bufs();
        for (int i = 0; i < n; i++) begin
            tx_d.push_back(16'((i % 8) * 256 + $urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) tx_d[i] = -tx_d[i];
            tx_l.push_back(1'($urandom));
            ex_d.push_back(16'(model_y(tx_d[i])));
        end
        run_stream(1, 1, 20 * n + 50);
        vectors++;
        if (rx_d.size() != tx_d.size()) begin miscompares++; $display("FAIL %s_count got=%0d want=%0d", name, rx_d.size(), tx_d.size()); end
        for (int i = 0; i < rx_d.size() && i < ex_d.size(); i++) begin
            vectors++;
            if (rx_d[i] !== ex_d[i] || rx_l[i] !== tx_l[i]) begin
                miscompares++;
                $display("FAIL %s[%0d] x=%h got=%h/%b want=%h/%b", name, i, tx_d[i], rx_d[i], rx_l[i], ex_d[i], tx_l[i]);
            end
        end
    endtask

    task automatic test_partial_load();
        tap_q.delete();
        for (int k = 0; k < 3; k++) tap_q.push_back($urandom_range(512, 3000));
        load_taps(1);
        tap_q.delete();
        for (int k = 0; k < 3; k++) tap_q.push_back($urandom_range(512, 3000));
        load_taps(1);
        stream_model_check("partial", 40);
    endtask

    task automatic test_clear();
        int a_val, b_val;
        tap_q.delete();
        tap_q.push_back(1500); tap_q.push_back(1700);
        load_taps(0);
        a_val = $urandom_range(100, 4000);
        b_val = $urandom_range(100, 4000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_if.tvalid = 1; in_if.tdata = 16'h0100 * 16'(i + 1); in_if.tlast = 0;
        end
        @(negedge clk);
        in_if.tvalid = 0;
        clear = 1;
        taps_if.tvalid = 1; taps_if.tdata = 16'(a_val); taps_if.tlast = 0;
        m_gain[m_ptr] = a_val;
        m_ptr = 0;
        @(negedge clk);
        clear = 0;
        taps_if.tvalid = 0;
        vectors++;
        if (out_if.tvalid !== 1'b0 || out_if.tdata !== 16'h0) begin
            miscompares++;
            $display("FAIL clear_flush got v=%b d=%h want v=0 d=0000", out_if.tvalid, out_if.tdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (out_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL clear_drain[%0d] got=%b want=0", i, out_if.tvalid); end
        end
        tap_q.delete();
        tap_q.push_back(b_val);
        load_taps(0);
        stream_model_check("clear", 40);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_if.tvalid = 1; in_if.tdata = 16'h0210; in_if.tlast = 0;
        end
        @(negedge clk);
        in_if.tvalid = 0;
        vectors++;
        if (out_if.tvalid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_valid got=%b want=1", out_if.tvalid); end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (out_if.tvalid !== 1'b0 || out_if.tdata !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b d=%h want v=0 d=0000", out_if.tvalid, out_if.tdata);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        stream_model_check("post_reset", 40);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_unity_ramp();
        test_gain2_saturation();
        test_ramp_taps();
        test_back_to_back_stall();
        test_partial_load();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_amp_predistort
`default_nettype wire
